// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, RGB565 bar colours and the coordinate type
// shared by vga_timing_ctrl.
package vga_pkg;
  typedef logic [9:0] coord_t;
  localparam coord_t H_SYNC      = 10'd96;
  localparam coord_t H_BACK      = 10'd48;
  localparam coord_t H_ACTIVE    = 10'd640;
  localparam coord_t H_FRONT     = 10'd16;
  localparam coord_t V_SYNC      = 10'd2;
  localparam coord_t V_BACK      = 10'd33;
  localparam coord_t V_ACTIVE    = 10'd480;
  localparam coord_t V_FRONT     = 10'd10;
  localparam coord_t H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam coord_t V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam coord_t H_LAST      = H_TOTAL - 10'd1;
  localparam coord_t V_LAST      = V_TOTAL - 10'd1;
  localparam coord_t H_ACT_START = H_SYNC + H_BACK;
  localparam coord_t H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam coord_t V_ACT_START = V_SYNC + V_BACK;
  localparam coord_t V_ACT_END   = V_ACT_START + V_ACTIVE;
  localparam coord_t BAR_W       = 10'd80;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;
  localparam logic [15:0] BAR_COLORS [8] =
    '{C_WHITE, C_YELLOW, C_CYAN, C_GREEN, C_MAGENTA, C_RED, C_BLUE, C_BLACK};

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction
endpackage

// File: rtl/vga_timing_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;

  always_ff @(posedge clk)
    if (rst) {o_q, r_meta} <= 2'b00;
    else     {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing generator with a 2-stage output pipeline.
// Define VGA_TEST_PATTERN_EN to replace pix_data with 8 vertical colour bars.
module vga_timing_ctrl
  import vga_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        locked,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_de,
  output logic [15:0] rgb,
  output logic        frame_start
);
  logic   w_run;
  coord_t r_cnt_h, r_cnt_v;
  logic   r_hs1, r_vs1, r_org1;
  logic   w_h_sync, w_v_sync, w_act;

  sync_2ff u_sync (.clk(sys_clk), .rst(sys_rst), .i_d(locked), .o_q(w_run));

  assign w_h_sync = r_cnt_h < H_SYNC;
  assign w_v_sync = r_cnt_v < V_SYNC;
  assign w_act    = r_cnt_h >= H_ACT_START && r_cnt_h < H_ACT_END &&
                    r_cnt_v >= V_ACT_START && r_cnt_v < V_ACT_END;

  // Losing lock drops the whole pipeline so a relock always begins a fresh frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !w_run) begin
      r_cnt_h     <= '0;
      r_cnt_v     <= '0;
      r_hs1       <= 1'b0;
      r_vs1       <= 1'b0;
      r_org1      <= 1'b0;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_cnt_h     <= (r_cnt_h == H_LAST) ? '0 : r_cnt_h + 1'b1;
      if (r_cnt_h == H_LAST) r_cnt_v <= (r_cnt_v == V_LAST) ? '0 : r_cnt_v + 1'b1;
      r_hs1       <= w_h_sync;
      r_vs1       <= w_v_sync;
      r_org1      <= r_cnt_h == '0 && r_cnt_v == '0;
      pix_req     <= w_act;
      pix_x       <= w_act ? r_cnt_h - H_ACT_START : '0;
      pix_y       <= w_act ? r_cnt_v - V_ACT_START : '0;
      hsync       <= !r_hs1;
      vsync       <= !r_vs1;
      rgb_de      <= pix_req;
      frame_start <= r_org1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] w_bar, r_bar;
  logic       w_unused_pix;
  assign w_bar        = 3'(pix_x / BAR_W);
  assign w_unused_pix = ^pix_data;
  always_ff @(posedge sys_clk) r_bar <= (sys_rst || !w_run) ? '0 : w_bar;
  assign rgb = rgb_de ? bar_color(r_bar) : '0;
`else
  assign rgb = rgb_de ? pix_data : '0;
`endif
endmodule
